// File: rtl/mont_exp_ctrl_if.sv
// mont_exp_ctrl_if: request/result and Montgomery multiplier handshake bundle for mont_exp_ctrl
interface mont_exp_ctrl_if #(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
);
  logic             i_start;
  logic [WIDTH-1:0] i_N;
  logic [WIDTH-1:0] i_base;
  logic [EXP_W-1:0] i_exp;
  logic [WIDTH-1:0] i_r2;
  logic             o_busy;
  logic [WIDTH-1:0] o_result;
  logic             o_done;
  logic             o_mm_start;
  logic [WIDTH-1:0] o_mm_N;
  logic [WIDTH-1:0] o_mm_a;
  logic [WIDTH-1:0] o_mm_b;
  logic [WIDTH-1:0] i_mm_result;
  logic             i_mm_finished;
  modport slave (
    input  i_start, i_N, i_base, i_exp, i_r2, i_mm_result, i_mm_finished,
    output o_busy, o_result, o_done, o_mm_start, o_mm_N, o_mm_a, o_mm_b
  );
  modport master (
    output i_start, i_N, i_base, i_exp, i_r2, i_mm_result, i_mm_finished,
    input  o_busy, o_result, o_done, o_mm_start, o_mm_N, o_mm_a, o_mm_b
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: base^exp mod N by sequencing an external Montgomery multiplier; define MONT_LADDER_EN for the constant-time ladder
module mont_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int EXP_W = 256
) (
  input logic i_clk,
  input logic i_rst,
  mont_exp_ctrl_if.slave bus
);
  localparam int IW = EXP_W > 1 ? $clog2(EXP_W) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [2:0] {IDLE, TO_MONT_B, TO_MONT_ONE, SQUARE, MULT, FROM_MONT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, r2_q, r2_d, bm_q, bm_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IW-1:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d, start_q, start_d;
  logic bit_s, last_s, fin;
  logic [WIDTH-1:0] res;
  assign bit_s = exp_q[idx_q];
  assign last_s = idx_q == '0;
  assign fin = bus.i_mm_finished;
  assign res = bus.i_mm_result;
  assign bus.o_busy = busy_q;
  assign bus.o_result = result_q;
  assign bus.o_done = done_q;
  assign bus.o_mm_start = start_q;
  assign bus.o_mm_N = n_q;
  assign bus.o_mm_a = a_q;
  assign bus.o_mm_b = b_q;
  // next-state: each finished multiply captures its result and launches the following one
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    r2_d = r2_q;
    bm_d = bm_q;
    acc_d = acc_q;
    result_d = result_q;
    a_d = a_q;
    b_d = b_q;
    exp_d = exp_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        state_d = TO_MONT_B;
        n_d = bus.i_N;
        r2_d = bus.i_r2;
        exp_d = bus.i_exp;
        idx_d = IW'(EXP_W - 1);
        a_d = bus.i_base;
        b_d = bus.i_r2;
        start_d = 1'b1;
        busy_d = 1'b1;
      end
      TO_MONT_B: if (fin) begin
        bm_d = res;
        state_d = TO_MONT_ONE;
        a_d = ONE;
        b_d = r2_q;
        start_d = 1'b1;
      end
      TO_MONT_ONE: if (fin) begin
        acc_d = res;
        state_d = SQUARE;
        a_d = res;
`ifdef MONT_LADDER_EN
        b_d = bm_q;
`else
        b_d = res;
`endif
        start_d = 1'b1;
      end
`ifdef MONT_LADDER_EN
      SQUARE: if (fin) begin
        acc_d = bit_s ? res : acc_q;
        bm_d = bit_s ? bm_q : res;
        state_d = MULT;
        a_d = bit_s ? bm_q : acc_q;
        b_d = bit_s ? bm_q : acc_q;
        start_d = 1'b1;
      end
      MULT: if (fin) begin
        acc_d = bit_s ? acc_q : res;
        bm_d = bit_s ? res : bm_q;
        state_d = last_s ? FROM_MONT : SQUARE;
        idx_d = last_s ? idx_q : idx_q - 1'b1;
        a_d = acc_d;
        b_d = last_s ? ONE : bm_d;
        start_d = 1'b1;
      end
`else
      SQUARE: if (fin) begin
        acc_d = res;
        state_d = bit_s ? MULT : last_s ? FROM_MONT : SQUARE;
        idx_d = (bit_s || last_s) ? idx_q : idx_q - 1'b1;
        a_d = res;
        b_d = bit_s ? bm_q : last_s ? ONE : res;
        start_d = 1'b1;
      end
      MULT: if (fin) begin
        acc_d = res;
        state_d = last_s ? FROM_MONT : SQUARE;
        idx_d = last_s ? idx_q : idx_q - 1'b1;
        a_d = res;
        b_d = last_s ? ONE : res;
        start_d = 1'b1;
      end
`endif
      FROM_MONT: if (fin) begin
        result_d = res;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      n_q <= '0;
      r2_q <= '0;
      bm_q <= '0;
      acc_q <= '0;
      result_q <= '0;
      a_q <= '0;
      b_q <= '0;
      exp_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      r2_q <= r2_d;
      bm_q <= bm_d;
      acc_q <= acc_d;
      result_q <= result_d;
      a_q <= a_d;
      b_q <= b_d;
      exp_q <= exp_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      start_q <= start_d;
    end
  end
endmodule
